// File: rtl/avalon_regfile_decoder.sv
// Avalon-MM slave with NUM_REGS data registers plus a status register.
// Provides HPS load strobes, one-cycle read latency and per-register dirty handshakes with card logic.

module avalon_regfile_lane #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hps_we,
    input  logic [DATA_W-1:0] hps_wdata,
    input  logic              card_we,
    input  logic [DATA_W-1:0] card_wdata,
    input  logic              card_ack,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] q_nxt,
    output logic              load,
    output logic              dirty,
    output logic              dirty_nxt
);

    // HPS data beats a coincident card write; a set beats a coincident ack
    always_comb begin
        q_nxt = q;
        if (hps_we)
            q_nxt = hps_wdata;
        else if (card_we)
            q_nxt = card_wdata;
    end

    assign dirty_nxt = hps_we | (dirty & ~card_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RESET_VAL;
            load  <= 1'b0;
            dirty <= 1'b0;
        end else begin
            q     <= q_nxt;
            load  <= hps_we;
            dirty <= dirty_nxt;
        end
    end

endmodule

module avalon_regfile_decoder #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter int                NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         avs_chipselect,
    input  logic [ADDR_W-1:0]            avs_address,
    input  logic                         avs_write,
    input  logic [DATA_W-1:0]            avs_writedata,
    input  logic                         avs_read,
    output logic [DATA_W-1:0]            avs_readdata,
    output logic                         avs_readdatavalid,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_load,
    input  logic [NUM_REGS-1:0]          card_we,
    input  logic [NUM_REGS*DATA_W-1:0]   card_wdata,
    input  logic [NUM_REGS-1:0]          card_ack,
    output logic [NUM_REGS-1:0]          reg_dirty,
    output logic                         addr_err
);

    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS);

    typedef struct packed {
        logic wr;     // legal single write
        logic rd;     // legal single read
        logic stat;   // address hits status register
        logic oob;    // address beyond status register
        logic proto;  // read and write together
    } dec_t;

    dec_t                              dec;
    logic [NUM_REGS-1:0][DATA_W-1:0]   q, q_nxt;
    logic [NUM_REGS-1:0]               hps_we, dirty_nxt;
    logic [DATA_W-1:0]                 rd_mux;
    logic                              err_set, err_clr;

    always_comb begin
        dec.wr    = avs_chipselect & avs_write & ~avs_read;
        dec.rd    = avs_chipselect & avs_read & ~avs_write;
        dec.proto = avs_chipselect & avs_read & avs_write;
        dec.stat  = (avs_address == STAT_ADDR);
        dec.oob   = (avs_address > STAT_ADDR);
    end

    assign err_set = dec.proto | ((dec.wr | dec.rd) & dec.oob);
    assign err_clr = dec.wr & dec.stat & avs_writedata[DATA_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_lane
            assign hps_we[gi] = dec.wr & (avs_address == ADDR_W'(gi));

            avalon_regfile_lane #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VAL)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .hps_we     (hps_we[gi]),
                .hps_wdata  (avs_writedata),
                .card_we    (card_we[gi]),
                .card_wdata (card_wdata[gi*DATA_W +: DATA_W]),
                .card_ack   (card_ack[gi]),
                .q          (q[gi]),
                .q_nxt      (q_nxt[gi]),
                .load       (reg_load[gi]),
                .dirty      (reg_dirty[gi]),
                .dirty_nxt  (dirty_nxt[gi])
            );

            assign reg_q[gi*DATA_W +: DATA_W] = q[gi];
        end
    endgenerate

    // Read data is taken from next-state values so same-cycle card updates show up
    always_comb begin
        rd_mux = '0;
        if (dec.stat) begin
            rd_mux[DATA_W-1]     = addr_err;
            rd_mux[NUM_REGS-1:0] = dirty_nxt;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (avs_address == ADDR_W'(i))
                    rd_mux = q_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            addr_err          <= 1'b0;
        end else begin
            avs_readdatavalid <= dec.rd;
            if (dec.rd)
                avs_readdata <= rd_mux;
            if (err_set)
                addr_err <= 1'b1;
            else if (err_clr)
                addr_err <= 1'b0;
        end
    end

endmodule
